// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 encodings and FSM state types for the memory responder
// Purpose: burst/resp/size encodings, write/read FSM state typedefs and a
//          helper that decides whether a burst shape is serviceable.
// Ports:   none (package).
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only full-word FIXED and INCR bursts touch memory; anything else runs
  // its beats but answers SLVERR.
  function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_4B);
  endfunction

endpackage

// File: rtl/axi4_mem_dp.sv
// rtl/axi4_mem_dp.sv - word memory with a byte-enabled write port and a registered read port
// Purpose: MEM_DEPTH x 32 storage. A read and a write to the same word on the
//          same edge return the old contents. Storage itself is not reset.
// Ports:   clk_i/rst_i     clock, async active-high reset (read register only)
//          we_i/waddr_i/wdata_i/wstrb_i   write port, byte lanes per wstrb_i
//          re_i/raddr_i/rdata_o           read port, rdata_o loads on re_i
module axi4_mem_dp #(
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 memory responder with independent write and read burst engines
// Purpose: accepts 24-bit-address / 32-bit-data AXI4 bursts into a word memory.
//          FIXED and INCR full-word bursts are serviced; other shapes run their
//          beats without touching memory and answer SLVERR.
// Ports:   s_axi_aclk/s_axi_areset   clock, async active-high reset
//          s_axi_aw*  write address channel (lock/cache/prot/qos/user ignored)
//          s_axi_w*   write data channel (wid ignored)
//          s_axi_b*   write response channel
//          s_axi_ar*  read address channel (lock/cache/prot/qos/user ignored)
//          s_axi_r*   read data channel
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ID_WIDTH  = 3
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [23:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic [1:0]          s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic [4:0]          s_axi_awuser,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ID_WIDTH-1:0] s_axi_wid,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [23:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [1:0]          s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic [4:0]          s_axi_aruser,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // ---------------- write engine ----------------
  wr_state_e           wr_state_q, wr_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                wfixed_q, wfixed_d;
  logic                wok_q, wok_d;
  logic                werr_q, werr_d;

  logic aw_hs, w_hs, b_hs;
  logic w_last_beat, w_err_now;
  logic mem_we;

  assign aw_hs       = s_axi_awvalid && awready_q;
  assign w_hs        = s_axi_wvalid && wready_q;
  assign b_hs        = bvalid_q && s_axi_bready;
  assign w_last_beat = (wcnt_q == wlen_q);
  // The burst length comes from awlen; wlast only has to agree with it.
  assign w_err_now   = werr_q || (s_axi_wlast != w_last_beat);

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    widx_d     = widx_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    wfixed_d   = wfixed_q;
    wok_d      = wok_q;
    werr_d     = werr_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        // awready is held low through reset and rises on the first edge after.
        awready_d = 1'b1;
        if (aw_hs) begin
          wr_state_d = W_DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          bid_d      = s_axi_awid;
          widx_d     = s_axi_awaddr[2 +: IDX_W];
          wlen_d     = s_axi_awlen;
          wcnt_d     = 8'd0;
          wfixed_d   = (s_axi_awburst == BURST_FIXED);
          wok_d      = burst_supported(s_axi_awburst, s_axi_awsize);
          werr_d     = 1'b0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          mem_we = wok_q;
          if (!wfixed_q) begin
            widx_d = widx_q + 1'b1;
          end
          if (w_last_beat) begin
            wr_state_d = W_RESP;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (!wok_q || w_err_now) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            werr_d = w_err_now;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      widx_q     <= '0;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wfixed_q   <= 1'b0;
      wok_q      <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      widx_q     <= widx_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      wfixed_q   <= wfixed_d;
      wok_q      <= wok_d;
      werr_q     <= werr_d;
    end
  end

  // ---------------- read engine ----------------
  rd_state_e           rd_state_q, rd_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;   // index of the next word to load
  logic [7:0]          rlen_q, rlen_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                rfixed_q, rfixed_d;

  logic             ar_hs, r_hs;
  logic [IDX_W-1:0] ar_idx;
  logic             mem_re;
  logic [IDX_W-1:0] mem_raddr;
  logic [31:0]      mem_rdata;

  assign ar_hs  = s_axi_arvalid && arready_q;
  assign r_hs   = rvalid_q && s_axi_rready;
  assign ar_idx = s_axi_araddr[2 +: IDX_W];

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    ridx_d     = ridx_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rfixed_d   = rfixed_q;
    mem_re     = 1'b0;
    mem_raddr  = ridx_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          // First beat is loaded on the handshake edge itself.
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          mem_re     = 1'b1;
          mem_raddr  = ar_idx;
          rid_d      = s_axi_arid;
          rlen_d     = s_axi_arlen;
          rcnt_d     = 8'd0;
          rlast_d    = (s_axi_arlen == 8'd0);
          rfixed_d   = (s_axi_arburst == BURST_FIXED);
          rresp_d    = burst_supported(s_axi_arburst, s_axi_arsize) ? RESP_OKAY : RESP_SLVERR;
          ridx_d     = (s_axi_arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rd_state_d = R_IDLE;
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
          end else begin
            mem_re  = 1'b1;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            if (!rfixed_q) begin
              ridx_d = ridx_q + 1'b1;
            end
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      ridx_q     <= '0;
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rfixed_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      ridx_q     <= ridx_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      rfixed_q   <= rfixed_d;
    end
  end

  axi4_mem_dp #(
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk_i  (s_axi_aclk),
    .rst_i  (s_axi_areset),
    .we_i   (mem_we),
    .waddr_i(widx_q),
    .wdata_i(s_axi_wdata),
    .wstrb_i(s_axi_wstrb),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  // Unsupported read bursts still fetch from memory; the data is blanked here.
  assign s_axi_rdata   = (rresp_q == RESP_SLVERR) ? 32'd0 : mem_rdata;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wid,
                           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awuser,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_aruser};

endmodule
